// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the programmable terminal-count timer.
package prog_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_prescaler.sv
// Step-strobe generator: pulses strobe once every PRESCALE cycles; clr restarts the phase.
module prog_timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic strobe
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign strobe = (r_cnt == LAST);

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable terminal-count timer with one-shot/periodic modes, start/stop and tick.
// Optional step prescaler enabled by defining PROG_TIMER_PRESCALE_EN.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_count,  w_count_nxt;
  logic [WIDTH-1:0] r_limit,  w_limit_nxt;
  logic             r_mode,   w_mode_nxt;
  logic             r_tick,   w_tick_nxt;
  logic             w_step;

`ifdef PROG_TIMER_PRESCALE_EN
  prog_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (start | stop),
    .strobe (w_step)
  );
`else
  logic w_unused_prescale;
  assign w_unused_prescale = (PRESCALE >= 2);
  assign w_step            = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_mode_nxt  = r_mode;
    w_tick_nxt  = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
          w_limit_nxt = limit;
          w_mode_nxt  = periodic;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_count_nxt = '0;
          w_limit_nxt = limit;
          w_mode_nxt  = periodic;
        end else if (w_step) begin
          if (r_count == r_limit) begin
            w_tick_nxt = 1'b1;
            if (r_mode == MODE_PERIODIC) begin
              w_count_nxt = '0;
            end else begin
              w_state_nxt = DONE;
            end
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_mode  <= MODE_ONESHOT;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
      r_mode  <= w_mode_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);

endmodule
